// File: rtl/data_mem_slave.sv
// Single-port data-memory slave: byte-enabled stores, full-word loads, fixed response latency.
// Optional macro DMEM_GNT_WAIT_EN adds a grant-wait phase of GNT_WAIT cycles before acceptance.
module data_mem_slave #(
    parameter int DEPTH_WORDS = 4096,
    parameter int RVALID_LAT  = 1,
    parameter int GNT_WAIT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_GNT_WAIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LAT = 2'd1, RESP = 2'd2, WAIT_GNT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LAT = 2'd1, RESP = 2'd2} state_t;
`endif

    state_t         state_q, state_d;
    logic [3:0]     lat_cnt_q, lat_cnt_d;
    logic           we_q, we_d;
    logic           in_range_q, in_range_d;
    logic [31:0]    rdata_q;
    logic           gnt_raw;
    logic           accept;
    logic           in_range;
    logic [AW-1:0]  word_idx;
    logic [3:0]     lane_we;
    logic [31:0]    mem [DEPTH_WORDS];
`ifdef DMEM_GNT_WAIT_EN
    logic [3:0]     wait_cnt_q, wait_cnt_d;
`endif

    assign word_idx = data_addr_i[AW+1:2];
    assign in_range = (data_addr_i[31:AW+2] == '0);

    // Grant is forced low while reset is held, even though the state is already IDLE.
    assign data_gnt_o = gnt_raw & reset;
    assign accept     = data_req_i & data_gnt_o;

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        we_d       = we_q;
        in_range_d = in_range_q;
        gnt_raw    = 1'b0;
`ifdef DMEM_GNT_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef DMEM_GNT_WAIT_EN
                if (data_req_i) begin
                    state_d    = WAIT_GNT;
                    wait_cnt_d = 4'(GNT_WAIT - 1);
                end
`else
                gnt_raw = data_req_i;
`endif
            end
`ifdef DMEM_GNT_WAIT_EN
            WAIT_GNT: begin
                if (!data_req_i) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == 4'd0) begin
                    gnt_raw = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
`endif
            LAT: begin
                if (lat_cnt_q <= 4'd1) begin
                    state_d   = RESP;
                    lat_cnt_d = 4'd0;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A latency of one skips LAT and responds on the very next cycle.
        if (accept) begin
            we_d       = data_we_i;
            in_range_d = in_range;
            lat_cnt_d  = 4'(RVALID_LAT - 1);
            state_d    = (RVALID_LAT == 1) ? RESP : LAT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lat_cnt_q  <= 4'd0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
`ifdef DMEM_GNT_WAIT_EN
            wait_cnt_q <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            we_q       <= we_d;
            in_range_q <= in_range_d;
`ifdef DMEM_GNT_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
        assign lane_we[gi] = accept & data_we_i & in_range & data_be_i[gi];
    end

    // Storage is never reset; the read register only updates on an accepted in-range load.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem[word_idx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
            end
        end
        if (accept && !data_we_i && in_range) begin
            rdata_q <= mem[word_idx];
        end
    end

    assign data_rvalid_o = (state_q == RESP);
    assign busy_o        = (state_q == LAT) || (state_q == RESP);
    assign data_rdata_o  = ((state_q == RESP) && !we_q && in_range_q) ? rdata_q : 32'h0;

`ifdef DMEM_GNT_WAIT_EN
    logic unused_bits;
    assign unused_bits = ^data_addr_i[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{data_addr_i[1:0], (GNT_WAIT > 0)};
`endif

endmodule

// File: tb/tb_data_mem_slave.sv
// Bench for data_mem_slave: two instances (latency 1 / depth 4096 and latency 3 / depth 16)
// checked against a transaction-level memory model; follows DMEM_GNT_WAIT_EN if defined.
module tb_data_mem_slave;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam int DEP0 = 4096;
    localparam int DEP1 = 16;
    localparam int GW   = 2;
`ifdef DMEM_GNT_WAIT_EN
    localparam int EXPW = GW;
`else
    localparam int EXPW = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_i   [2];
    logic [31:0] addr_i  [2];
    logic        we_i    [2];
    logic [3:0]  be_i    [2];
    logic [31:0] wdata_i [2];
    logic        gnt_o   [2];
    logic        rvalid_o[2];
    logic        busy_o  [2];
    logic [31:0] rdata_o [2];

    logic [31:0] mdl [2][4096];
    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_slave #(.DEPTH_WORDS(DEP0), .RVALID_LAT(LAT0), .GNT_WAIT(GW)) u_dut0 (
        .clk(clk), .reset(reset),
        .data_req_i(req_i[0]), .data_addr_i(addr_i[0]), .data_we_i(we_i[0]),
        .data_be_i(be_i[0]), .data_wdata_i(wdata_i[0]),
        .data_gnt_o(gnt_o[0]), .data_rvalid_o(rvalid_o[0]),
        .data_rdata_o(rdata_o[0]), .busy_o(busy_o[0])
    );

    data_mem_slave #(.DEPTH_WORDS(DEP1), .RVALID_LAT(LAT1), .GNT_WAIT(GW)) u_dut1 (
        .clk(clk), .reset(reset),
        .data_req_i(req_i[1]), .data_addr_i(addr_i[1]), .data_we_i(we_i[1]),
        .data_be_i(be_i[1]), .data_wdata_i(wdata_i[1]),
        .data_gnt_o(gnt_o[1]), .data_rvalid_o(rvalid_o[1]),
        .data_rdata_o(rdata_o[1]), .busy_o(busy_o[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic longint depth_of(input int d);
        return (d == 0) ? longint'(DEP0) : longint'(DEP1);
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [31:0] a);
        longint idx = longint'(a[31:2]);
        if (idx < depth_of(d)) return mdl[d][idx];
        return 32'h0;
    endfunction

    function automatic void model_store(input int d, input logic [31:0] a,
                                        input logic [3:0] be, input logic [31:0] wd);
        longint idx = longint'(a[31:2]);
        if (idx < depth_of(d)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endfunction

    // {wait cycles, latency, busy cycles, protocol glitch, rdata}
    function automatic logic [56:0] pack(input int w, input int l, input int b,
                                         input bit g, input logic [31:0] r);
        return {8'(w), 8'(l), 8'(b), g, r};
    endfunction

    // Drives one full transaction and reports what was observed alongside the model's expectation.
    task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output logic [56:0] got, output logic [56:0] want);
        int waits = 0;
        int lat = 0;
        int bcnt = 0;
        bit glitch = 1'b0;
        bit granted = 1'b0;
        logic [31:0] rd = 32'h0;
        want = pack(EXPW, lat_of(d), lat_of(d), 1'b0, we ? 32'h0 : model_load(d, a));
        req_i[d] = 1'b1; we_i[d] = we; addr_i[d] = a; be_i[d] = be; wdata_i[d] = wd;
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            if (busy_o[d]) bcnt++;
            if (rvalid_o[d] || rdata_o[d] !== 32'h0) glitch = 1'b1;
            if (gnt_o[d]) granted = 1'b1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        if (granted) begin
            @(posedge clk); #1;
            req_i[d] = 1'b0;
            if (we) model_store(d, a, be, wd);
            for (int k = 1; k <= 20 && lat == 0; k++) begin
                @(negedge clk);
                if (busy_o[d]) bcnt++;
                if (rvalid_o[d]) begin
                    lat = k;
                    rd = rdata_o[d];
                end else if (rdata_o[d] !== 32'h0) begin
                    glitch = 1'b1;
                end
                @(posedge clk); #1;
            end
            @(negedge clk);
            if (rvalid_o[d] || busy_o[d]) glitch = 1'b1;
            @(posedge clk); #1;
        end else begin
            req_i[d] = 1'b0;
        end
        got = pack(waits, lat, bcnt, glitch, rd);
        $display("dut%0d %s addr=%h be=%h wdata=%h : wait=%0d lat=%0d busy=%0d rdata=%h",
                 d, we ? "SW" : "LW", a, be, wd, waits, lat, bcnt, rd);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            req_i[d] = 1'b1; we_i[d] = 1'b0; addr_i[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({gnt_o[d], rvalid_o[d], busy_o[d], rdata_o[d]} !== 35'h0) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d: got gnt=%b rv=%b busy=%b rdata=%h want all 0",
                         d, gnt_o[d], rvalid_o[d], busy_o[d], rdata_o[d]);
            end
            req_i[d] = 1'b0;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({gnt_o[d], rvalid_o[d], busy_o[d]} !== 3'b000) begin
                miscompares++;
                $display("FAIL after_reset_idle dut%0d: got gnt=%b rv=%b busy=%b want 0",
                         d, gnt_o[d], rvalid_o[d], busy_o[d]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sw_lw();
        logic [56:0] g, w;
        txn(0, 1'b1, 32'h10, 4'hF, 32'hCAFEBABE, g, w);
        vectors++;
        if (g !== w) begin miscompares++; $display("FAIL sw_lw store: got %h want %h", g, w); end
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0, g, w);
        vectors++;
        if (g[31:0] !== 32'hCAFEBABE || g !== w) begin
            miscompares++; $display("FAIL sw_lw load: got %h want %h", g, w);
        end
    endtask

    task automatic test_byte_lanes();
        logic [56:0] g, w;
        bit          st_we [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        logic [31:0] st_a  [8] = '{32'h20, 32'h20, 32'h22, 32'h20, 32'h20, 32'h21, 32'h20, 32'h23};
        logic [3:0]  st_be [8] = '{4'hF, 4'hF, 4'h4, 4'h0, 4'hC, 4'hF, 4'h0, 4'h0};
        logic [31:0] st_wd [8] = '{32'h11223344, 32'h0, 32'h00AA0000, 32'h0,
                                   32'hBEEF0000, 32'h0, 32'hFFFFFFFF, 32'h0};
        logic [31:0] lit   [8] = '{32'h0, 32'h11223344, 32'h0, 32'h11AA3344,
                                   32'h0, 32'hBEEF3344, 32'h0, 32'hBEEF3344};
        for (int i = 0; i < 8; i++) begin
            txn(0, st_we[i], st_a[i], st_be[i], st_wd[i], g, w);
            vectors++;
            if (g !== w || g[31:0] !== lit[i]) begin
                miscompares++;
                $display("FAIL byte_lanes step%0d: got %h want %h (rdata %h)", i, g, w, lit[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [56:0] g, w;
        bit granted = 1'b0;
        logic [34:0] obs, expv;
        txn(1, 1'b1, 32'h10, 4'hF, 32'h13572468, g, w);
        vectors++;
        if (g !== w) begin miscompares++; $display("FAIL latency store: got %h want %h", g, w); end
        req_i[1] = 1'b1; we_i[1] = 1'b0; addr_i[1] = 32'h10; be_i[1] = 4'hF;
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            if (gnt_o[1]) granted = 1'b1;
            else begin @(posedge clk); #1; end
        end
        vectors++;
        if (!granted) begin
            miscompares++;
            $display("FAIL latency grant: got no grant within 20 cycles want grant");
            req_i[1] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        addr_i[1] = 32'h14;
        for (int k = 1; k <= LAT1; k++) begin
            @(negedge clk);
            obs  = {gnt_o[1], busy_o[1], rvalid_o[1], rdata_o[1]};
            expv = {1'b0, 1'b1, (k == LAT1), (k == LAT1) ? 32'h13572468 : 32'h0};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL latency T+%0d: got %h want %h", k, obs, expv);
            end
            if (k == LAT1) req_i[1] = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        vectors++;
        if ({busy_o[1], rvalid_o[1]} !== 2'b00) begin
            miscompares++;
            $display("FAIL latency after_resp: got busy=%b rv=%b want 0", busy_o[1], rvalid_o[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gnt_wait();
        logic [56:0] g, w;
        bit seen = 1'b0;
        txn(0, 1'b1, 32'h30, 4'hF, 32'h0F0F0F0F, g, w);
        vectors++;
        if (g !== w) begin miscompares++; $display("FAIL gnt_wait store: got %h want %h", g, w); end
        req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 32'h30; be_i[0] = 4'hF; wdata_i[0] = 32'hFFFFFFFF;
        @(negedge clk);
`ifdef DMEM_GNT_WAIT_EN
        vectors++;
        if (gnt_o[0] !== 1'b0) begin
            miscompares++; $display("FAIL gnt_wait idle_cycle: got gnt=%b want 0", gnt_o[0]);
        end
        @(posedge clk); #1;
        req_i[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (gnt_o[0] !== 1'b0) begin
            miscompares++; $display("FAIL gnt_wait dropped: got gnt=%b want 0", gnt_o[0]);
        end
`else
        vectors++;
        if (gnt_o[0] !== 1'b1) begin
            miscompares++; $display("FAIL same_cycle_gnt: got gnt=%b want 1", gnt_o[0]);
        end
        req_i[0] = 1'b0;
`endif
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (rvalid_o[0] || busy_o[0]) seen = 1'b1;
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL no_access: got rvalid/busy=1 want 0"); end
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h30, 4'hF, 32'h0, g, w);
        vectors++;
        if (g !== w) begin miscompares++; $display("FAIL gnt_wait reload: got %h want %h", g, w); end
    endtask

    task automatic test_out_of_range();
        logic [56:0] g, w;
        int          st_d  [7] = '{1, 1, 1, 1, 0, 0, 0};
        bit          st_we [7] = '{1, 1, 0, 0, 1, 1, 0};
        logic [31:0] st_a  [7] = '{32'h0, 32'h40, 32'h0, 32'h40, 32'h0, 32'h4000, 32'h4000};
        logic [31:0] st_wd [7] = '{32'hA5A50001, 32'hFFFFFFFF, 32'h0, 32'h0,
                                   32'h600DF00D, 32'hDEADBEEF, 32'h0};
        for (int i = 0; i < 7; i++) begin
            txn(st_d[i], st_we[i], st_a[i], 4'hF, st_wd[i], g, w);
            vectors++;
            if (g !== w) begin
                miscompares++; $display("FAIL out_of_range step%0d: got %h want %h", i, g, w);
            end
        end
        txn(0, 1'b0, 32'h0, 4'hF, 32'h0, g, w);
        vectors++;
        if (g[31:0] !== 32'h600DF00D) begin
            miscompares++; $display("FAIL oor_no_alias: got %h want 600df00d", g[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [56:0] g, w;
        bit granted = 1'b0;
        bit seen = 1'b0;
        req_i[1] = 1'b1; we_i[1] = 1'b1; addr_i[1] = 32'h8; be_i[1] = 4'hF; wdata_i[1] = 32'h5A5A5A5A;
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            if (gnt_o[1]) granted = 1'b1;
            else begin @(posedge clk); #1; end
        end
        vectors++;
        if (!granted) begin
            miscompares++; $display("FAIL reset_mid grant: got none want grant");
            req_i[1] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_i[1] = 1'b0;
        model_store(1, 32'h8, 4'hF, 32'h5A5A5A5A);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rvalid_o[1], busy_o[1], rdata_o[1]} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_mid in_reset: got rv=%b busy=%b rdata=%h want 0",
                     rvalid_o[1], busy_o[1], rdata_o[1]);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < LAT1 + 2; k++) begin
            @(negedge clk);
            if (rvalid_o[1] || busy_o[1]) seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL reset_mid discard: got rvalid after reset want none"); end
        txn(1, 1'b0, 32'h8, 4'hF, 32'h0, g, w);
        vectors++;
        if (g !== w || g[31:0] !== 32'h5A5A5A5A) begin
            miscompares++; $display("FAIL reset_mid persist: got %h want %h", g, w);
        end
        txn(0, 1'b0, 32'h20, 4'hF, 32'h0, g, w);
        vectors++;
        if (g !== w) begin miscompares++; $display("FAIL reset_persist dut0: got %h want %h", g, w); end
    endtask

    task automatic test_random();
        logic [56:0] g, w;
        int d, idx;
        logic [31:0] a;
        for (int dd = 0; dd < 2; dd++) begin
            for (int i = 0; i < 16; i++) begin
                txn(dd, 1'b1, 32'(i * 4), 4'hF, $urandom, g, w);
                vectors++;
                if (g !== w) begin miscompares++; $display("FAIL rand_init dut%0d w%0d: got %h want %h", dd, i, g, w); end
            end
        end
        for (int n = 0; n < 60; n++) begin
            d   = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 19));
            a   = (d == 0 && idx >= 16) ? 32'(32'h4000 + (idx - 16) * 4) : 32'(idx * 4);
            a[1:0] = 2'($urandom_range(0, 3));
            txn(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, g, w);
            vectors++;
            if (g !== w) begin miscompares++; $display("FAIL random #%0d dut%0d: got %h want %h", n, d, g, w); end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_i[d] = 1'b0; addr_i[d] = 32'h0; we_i[d] = 1'b0; be_i[d] = 4'h0; wdata_i[d] = 32'h0;
        end
        @(posedge clk); #1;
        test_reset();
        test_sw_lw();
        test_byte_lanes();
        test_latency();
        test_gnt_wait();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_slave.md
DATA_MEM_SLAVE -- requirements
Module: data_mem_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096; number of 32-bit words of backing storage; power of two, 16 to 65536.
REQ-002 Parameter RVALID_LAT, default 1; cycles from the grant edge to rvalid; legal range 1 to 15.
REQ-003 Parameter GNT_WAIT, default 2; grant wait cycles; legal range 1 to 15; only used when DMEM_GNT_WAIT_EN is defined.
REQ-004 Port clk, input, 1 bit; the single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit; asynchronous, active-low reset.
REQ-006 Port data_req_i, input, 1 bit; request from the data-memory stage.
REQ-007 Port data_addr_i, input, 32 bits; byte address, already offset-corrected upstream.
REQ-008 Port data_we_i, input, 1 bit; 1 = store, 0 = load.
REQ-009 Port data_be_i, input, 4 bits; byte enables for stores.
REQ-010 Port data_wdata_i, input, 32 bits; store data, lane-aligned.
REQ-011 Port data_gnt_o, output, 1 bit; request accepted this cycle.
REQ-012 Port data_rvalid_o, output, 1 bit; response valid, one-cycle pulse.
REQ-013 Port data_rdata_o, output, 32 bits; load data.
REQ-014 Port busy_o, output, 1 bit; a transaction is outstanding.

Function
REQ-015 The block SHALL implement the states IDLE, WAIT_GNT (present only with DMEM_GNT_WAIT_EN), LAT and RESP.
REQ-016 In IDLE without the macro, data_gnt_o SHALL equal data_req_i combinationally, giving a same-cycle grant.
REQ-017 data_gnt_o SHALL be 0 in every state other than IDLE or the final WAIT_GNT cycle.
REQ-018 Acceptance SHALL be data_req_i and data_gnt_o high at a rising edge; at that edge the block SHALL capture address, we and be.
REQ-019 A store SHALL write only the bytes whose data_be_i bit is set, at the acceptance edge.
REQ-020 A store with data_be_i = 0 SHALL leave memory unchanged and still produce rvalid.
REQ-021 A load SHALL return the full word at the acceptance edge, independent of be.
REQ-022 Word index SHALL be data_addr_i[31:2]; data_addr_i[1:0] SHALL be ignored.
REQ-023 An address with index >= DEPTH_WORDS is out of range: stores SHALL be dropped, loads SHALL return 32'h0, and rvalid SHALL still be produced.
REQ-024 After acceptance the block SHALL enter LAT; a 4-bit counter SHALL load RVALID_LAT-1.
REQ-025 data_rvalid_o SHALL be high exactly RVALID_LAT cycles after the acceptance edge, for exactly one cycle, in state RESP.
REQ-026 RESP SHALL return to IDLE on the next edge.
REQ-027 No request SHALL be granted in RESP; the minimum acceptance-to-acceptance spacing is RVALID_LAT+1 cycles.
REQ-028 data_rdata_o SHALL be 32'h0 whenever data_rvalid_o is 0; for stores it SHALL be 32'h0 during rvalid.
REQ-029 busy_o SHALL be high from the cycle after acceptance through the RESP cycle inclusive.
REQ-030 data_req_i dropping in WAIT_GNT before grant SHALL return the block to IDLE with no access performed.
REQ-031 Exactly one transaction SHALL be outstanding at a time; there is no queueing.

Reset
REQ-032 While reset = 0: state IDLE, counter 0, data_gnt_o 0, data_rvalid_o 0, data_rdata_o 0, busy_o 0.
REQ-033 Reset mid-transaction SHALL discard the pending response without emitting rvalid.
REQ-034 Storage contents SHALL NOT be cleared by reset; a store already performed persists.
REQ-035 Operation SHALL resume on the first rising edge after reset deasserts.

Configuration
REQ-036 Macro DMEM_GNT_WAIT_EN defined: a request in IDLE SHALL move the block to WAIT_GNT with the grant deasserted; data_gnt_o SHALL assert in the GNT_WAIT-th WAIT_GNT cycle if data_req_i is still high.
REQ-037 Macro DMEM_GNT_WAIT_EN undefined: the WAIT_GNT state and its counter SHALL be absent, and the grant is same-cycle per REQ-016.

Verification
REQ-038 Macro off, RVALID_LAT=1: SW addr 0x10 wdata 0xCAFEBABE be 0xF, then LW 0x10 -> gnt in the same cycle each time; rvalid one cycle after each grant; load rdata 0xCAFEBABE.
REQ-039 Byte lanes: word 0x20 = 0x11223344; SB be 0x4 wdata 0x00AA0000; LW 0x20 -> 0x11AA3344; SH be 0xC wdata 0xBEEF0000, then LW -> 0xBEEF3344.
REQ-040 RVALID_LAT=3: LW accepted at cycle T -> rvalid only at T+3; req asserted at T+1..T+3 -> no gnt; busy_o high T+1..T+3.
REQ-041 Macro on, GNT_WAIT=2: req held from cycle T -> gnt at T+2 only; req dropped at T+1 -> no access and no rvalid; DEPTH_WORDS=16, LW 0x40 -> rvalid with rdata 0.
REQ-042 Reset: drive reset low in the LAT cycle after SW 0x8 = 0x5A5A5A5A -> no rvalid; after release, LW 0x8 -> 0x5A5A5A5A.
